// File: rtl/writeback_scoreboard.sv
// -----------------------------------------------------------------------------
// writeback_scoreboard
//
// Writeback stage plus the producer side of the decode register scoreboard.
// The MEM/WB result is registered once and drives the register-file write
// port. A small pending-write counter per architectural register is
// incremented when decode issues a register-writing instruction and
// decremented when the matching write reaches the register file. The counters
// give per-register busy flags, the RAW stall for the two decode sources and
// a saturation indication for the destination being issued.
//
// Ports
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   issue_valid           decode issued an instruction this cycle
//   issue_reg_write       issued instruction writes a register
//   issue_dst[4:0]        destination of the issued instruction
//   flush                 synchronous clear of every pending counter
//   wb_valid              MEM/WB result present
//   wb_reg_write          result writes the register file
//   wb_mem_to_reg         1: mem_data_out, 0: alu_data_out
//   wb_dst[4:0]           result destination
//   alu_data_out[31:0]    ALU result
//   mem_data_out[31:0]    load data
//   inst_read_reg_addr1/2 decode source registers
//   reg_write             register-file write enable (registered)
//   reg_wr_addr_wb[4:0]   register-file write address (registered)
//   reg_wr_data[31:0]     register-file write data (registered)
//   stall_flag_out        RAW hazard on either decode source
//   issue_full            counter of issue_dst is saturated
//   busy_flags[31:0]      bit i set while register i has a pending write
//   wb_underflow          sticky: a retire hit a zero counter
// -----------------------------------------------------------------------------
module writeback_scoreboard #(
    parameter int PEND_W = 2,
    parameter int NREG   = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        issue_valid,
    input  logic        issue_reg_write,
    input  logic [4:0]  issue_dst,
    input  logic        flush,
    input  logic        wb_valid,
    input  logic        wb_reg_write,
    input  logic        wb_mem_to_reg,
    input  logic [4:0]  wb_dst,
    input  logic [31:0] alu_data_out,
    input  logic [31:0] mem_data_out,
    input  logic [4:0]  inst_read_reg_addr1,
    input  logic [4:0]  inst_read_reg_addr2,
    output logic        reg_write,
    output logic [4:0]  reg_wr_addr_wb,
    output logic [31:0] reg_wr_data,
    output logic        stall_flag_out,
    output logic        issue_full,
    output logic [31:0] busy_flags,
    output logic        wb_underflow
);

    localparam logic [PEND_W-1:0] C_CNT_MAX  = {PEND_W{1'b1}};
    localparam logic [PEND_W-1:0] C_CNT_ZERO = {PEND_W{1'b0}};

    logic [PEND_W-1:0] r_cnt [NREG];
    logic              r_reg_write;
    logic [4:0]        r_reg_wr_addr;
    logic [31:0]       r_reg_wr_data;
    logic              r_underflow;

    logic              w_issue_ok;
    logic              w_retire_zero;
    logic [NREG-1:0]   w_busy;

    // Issue is accepted only for a real destination with room left in its counter.
    always_comb begin
        w_issue_ok = issue_valid && issue_reg_write && (issue_dst != 5'd0) && !issue_full;
    end

    // A retire on an empty counter is an underflow unless a same-register
    // issue in the same cycle cancels it out.
    always_comb begin
        w_retire_zero = r_reg_write
                        && (r_cnt[r_reg_wr_addr] == C_CNT_ZERO)
                        && !(w_issue_ok && (issue_dst == r_reg_wr_addr));
    end

    // Write port: enable is qualified, address and data are captured every cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_reg_write   <= 1'b0;
            r_reg_wr_addr <= 5'd0;
            r_reg_wr_data <= 32'd0;
        end else begin
            r_reg_write   <= wb_valid && wb_reg_write && (wb_dst != 5'd0);
            r_reg_wr_addr <= wb_dst;
            r_reg_wr_data <= wb_mem_to_reg ? mem_data_out : alu_data_out;
        end
    end

    // Sticky underflow flag; only reset clears it, and flush suppresses retires.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_underflow <= 1'b0;
        end else if (!flush && w_retire_zero) begin
            r_underflow <= 1'b1;
        end else begin
            r_underflow <= r_underflow;
        end
    end

    // Per-register pending-write counters. Register 0 can never see an
    // increment (issue_dst != 0) or a decrement (reg_write excludes 0).
    for (genvar g = 0; g < NREG; g++) begin : g_cnt
        logic w_inc;
        logic w_dec;

        // Decode this register's increment/decrement requests.
        always_comb begin
            w_inc = w_issue_ok && (issue_dst == g[4:0]);
            w_dec = r_reg_write && (r_reg_wr_addr == g[4:0]);
        end

        // Counter update: flush wins, same-cycle inc+dec cancels, floor at 0.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_cnt[g] <= C_CNT_ZERO;
            end else if (flush) begin
                r_cnt[g] <= C_CNT_ZERO;
            end else if (w_inc && !w_dec) begin
                r_cnt[g] <= r_cnt[g] + {{(PEND_W-1){1'b0}}, 1'b1};
            end else if (w_dec && !w_inc && (r_cnt[g] != C_CNT_ZERO)) begin
                r_cnt[g] <= r_cnt[g] - {{(PEND_W-1){1'b0}}, 1'b1};
            end else begin
                r_cnt[g] <= r_cnt[g];
            end
        end

        // Busy flag for this register.
        always_comb begin
            w_busy[g] = (r_cnt[g] != C_CNT_ZERO);
        end
    end

    // Hazard and saturation views derived from the registered counters only.
    always_comb begin
        stall_flag_out = w_busy[inst_read_reg_addr1] | w_busy[inst_read_reg_addr2];
        issue_full     = (r_cnt[issue_dst] == C_CNT_MAX);
    end

    assign busy_flags     = w_busy;
    assign reg_write      = r_reg_write;
    assign reg_wr_addr_wb = r_reg_wr_addr;
    assign reg_wr_data    = r_reg_wr_data;
    assign wb_underflow   = r_underflow;

endmodule

// File: tb/tb_writeback_scoreboard.sv
module tb_writeback_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic        issue_valid, issue_reg_write, flush;
    logic [4:0]  issue_dst;
    logic        wb_valid, wb_reg_write, wb_mem_to_reg;
    logic [4:0]  wb_dst;
    logic [31:0] alu_data_out, mem_data_out;
    logic [4:0]  inst_read_reg_addr1, inst_read_reg_addr2;
    logic        reg_write;
    logic [4:0]  reg_wr_addr_wb;
    logic [31:0] reg_wr_data;
    logic        stall_flag_out, issue_full, wb_underflow;
    logic [31:0] busy_flags;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
    } wb_exp_t;

    wb_exp_t wb_q[$];

    always #5 clk = ~clk;

    writeback_scoreboard #(.PEND_W(2), .NREG(32)) dut (
        .clk                 (clk),
        .reset               (reset),
        .issue_valid         (issue_valid),
        .issue_reg_write     (issue_reg_write),
        .issue_dst           (issue_dst),
        .flush               (flush),
        .wb_valid            (wb_valid),
        .wb_reg_write        (wb_reg_write),
        .wb_mem_to_reg       (wb_mem_to_reg),
        .wb_dst              (wb_dst),
        .alu_data_out        (alu_data_out),
        .mem_data_out        (mem_data_out),
        .inst_read_reg_addr1 (inst_read_reg_addr1),
        .inst_read_reg_addr2 (inst_read_reg_addr2),
        .reg_write           (reg_write),
        .reg_wr_addr_wb      (reg_wr_addr_wb),
        .reg_wr_data         (reg_wr_data),
        .stall_flag_out      (stall_flag_out),
        .issue_full          (issue_full),
        .busy_flags          (busy_flags),
        .wb_underflow        (wb_underflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic v, input logic [4:0] d);
        issue_valid     = v;
        issue_reg_write = v;
        issue_dst       = d;
    endtask

    // Drive one MEM/WB result and push what the write port must show next cycle.
    task automatic drive_wb(input logic m2r, input logic [4:0] d,
                            input logic [31:0] alu, input logic [31:0] mem);
        wb_exp_t e;
        wb_valid      = 1'b1;
        wb_reg_write  = 1'b1;
        wb_mem_to_reg = m2r;
        wb_dst        = d;
        alu_data_out  = alu;
        mem_data_out  = mem;
        e.we   = (d != 5'd0);
        e.addr = d;
        e.data = m2r ? mem : alu;
        wb_q.push_back(e);
    endtask

    task automatic idle_wb();
        wb_valid     = 1'b0;
        wb_reg_write = 1'b0;
    endtask

    task automatic check_wb(input string tag);
        wb_exp_t e;
        total++;
        assert (wb_q.size() != 0) else begin
            bad++;
            $error("FAIL %s_queue: observed=empty expected=entry", tag);
        end
        if (wb_q.size() != 0) begin
            e = wb_q.pop_front();
            chk({tag, "_we"},   {31'd0, reg_write},      {31'd0, e.we});
            chk({tag, "_addr"}, {27'd0, reg_wr_addr_wb}, {27'd0, e.addr});
            chk({tag, "_data"}, reg_wr_data,             e.data);
        end
    endtask

    initial begin
        reset = 1'b1;
        issue(1'b0, 5'd0);
        flush = 1'b0;
        idle_wb();
        wb_mem_to_reg = 1'b0;
        wb_dst = 5'd0;
        alu_data_out = 32'd0;
        mem_data_out = 32'd0;
        inst_read_reg_addr1 = 5'd0;
        inst_read_reg_addr2 = 5'd0;
        #12;
        chk("rst_we",    {31'd0, reg_write}, 32'd0);
        chk("rst_addr",  {27'd0, reg_wr_addr_wb}, 32'd0);
        chk("rst_data",  reg_wr_data, 32'd0);
        chk("rst_busy",  busy_flags, 32'd0);
        chk("rst_stall", {31'd0, stall_flag_out}, 32'd0);
        chk("rst_uf",    {31'd0, wb_underflow}, 32'd0);
        reset = 1'b0;

        // Basic issue / ALU writeback on $5.
        issue(1'b1, 5'd5);
        tick();
        issue(1'b0, 5'd0);
        inst_read_reg_addr1 = 5'd5;
        #1;
        chk("t1_stall", {31'd0, stall_flag_out}, 32'd1);
        chk("t1_busy",  busy_flags, 32'h0000_0020);
        drive_wb(1'b0, 5'd5, 32'h0000_1234, 32'h5555_5555);
        tick();
        idle_wb();
        check_wb("t1_wb");
        chk("t1_busy_land", busy_flags, 32'h0000_0020);
        tick();
        chk("t1_busy_clr",  busy_flags, 32'd0);
        chk("t1_stall_clr", {31'd0, stall_flag_out}, 32'd0);

        // Load writeback on $9 (issued first so no underflow).
        issue(1'b1, 5'd9);
        tick();
        issue(1'b0, 5'd0);
        drive_wb(1'b1, 5'd9, 32'h1111_1111, 32'hDEAD_BEEF);
        tick();
        idle_wb();
        check_wb("t2_wb");
        tick();
        chk("t2_busy", busy_flags, 32'd0);

        // Saturate $7, extra issue ignored, then drain.
        for (int i = 0; i < 3; i++) begin
            issue(1'b1, 5'd7);
            tick();
        end
        issue(1'b0, 5'd7);
        #1;
        chk("t3_full", {31'd0, issue_full}, 32'd1);
        issue(1'b1, 5'd7);
        tick();
        issue(1'b0, 5'd7);
        #1;
        chk("t3_full_hold", {31'd0, issue_full}, 32'd1);
        chk("t3_busy_hold", busy_flags, 32'h0000_0080);
        for (int i = 0; i < 3; i++) begin
            drive_wb(1'b0, 5'd7, 32'h70 + i, 32'd0);
            tick();
            check_wb("t3_wb");
        end
        idle_wb();
        chk("t3_full_drop", {31'd0, issue_full}, 32'd0);
        tick();
        chk("t3_busy_clr", busy_flags, 32'd0);
        chk("t3_uf",       {31'd0, wb_underflow}, 32'd0);

        // Simultaneous issue and retire on $3, then underflow.
        issue(1'b1, 5'd3);
        tick();
        issue(1'b0, 5'd0);
        drive_wb(1'b0, 5'd3, 32'h33, 32'd0);
        tick();
        idle_wb();
        check_wb("t4_wb_a");
        issue(1'b1, 5'd3);
        tick();
        issue(1'b0, 5'd3);
        #1;
        chk("t4_busy_same", busy_flags, 32'h0000_0008);
        chk("t4_full_same", {31'd0, issue_full}, 32'd0);
        drive_wb(1'b0, 5'd3, 32'h34, 32'd0);
        tick();
        idle_wb();
        check_wb("t4_wb_b");
        tick();
        chk("t4_busy_clr", busy_flags, 32'd0);
        chk("t4_uf_none",  {31'd0, wb_underflow}, 32'd0);
        drive_wb(1'b0, 5'd3, 32'h35, 32'd0);
        tick();
        idle_wb();
        check_wb("t4_wb_c");
        tick();
        chk("t4_uf_set",  {31'd0, wb_underflow}, 32'd1);
        chk("t4_busy_uf", busy_flags, 32'd0);
        tick();
        chk("t4_uf_stick", {31'd0, wb_underflow}, 32'd1);

        // Register 0: never written, never counted, never stalls.
        issue(1'b1, 5'd0);
        drive_wb(1'b0, 5'd0, 32'h0000_AAAA, 32'd0);
        #1;
        chk("t5_full0", {31'd0, issue_full}, 32'd0);
        tick();
        idle_wb();
        issue(1'b0, 5'd0);
        check_wb("t5_wb");
        inst_read_reg_addr1 = 5'd0;
        inst_read_reg_addr2 = 5'd0;
        #1;
        chk("t5_busy",  busy_flags, 32'd0);
        chk("t5_stall", {31'd0, stall_flag_out}, 32'd0);

        // Flush with in-flight write and competing issue.
        issue(1'b1, 5'd4);
        tick();
        issue(1'b1, 5'd6);
        tick();
        issue(1'b0, 5'd0);
        inst_read_reg_addr2 = 5'd6;
        #1;
        chk("t6_busy", busy_flags, 32'h0000_0050);
        chk("t6_stall_src2", {31'd0, stall_flag_out}, 32'd1);
        drive_wb(1'b0, 5'd6, 32'h66, 32'd0);
        tick();
        idle_wb();
        check_wb("t6_wb");
        flush = 1'b1;
        issue(1'b1, 5'd8);
        tick();
        flush = 1'b0;
        issue(1'b0, 5'd0);
        chk("t6_busy_flush", busy_flags, 32'd0);
        chk("t6_we_after",   {31'd0, reg_write}, 32'd0);

        // Asynchronous reset in the middle of a writeback.
        issue(1'b1, 5'd5);
        tick();
        issue(1'b0, 5'd0);
        drive_wb(1'b1, 5'd5, 32'd0, 32'hCAFE_F00D);
        tick();
        idle_wb();
        check_wb("t7_wb");
        #1;
        reset = 1'b1;
        #1;
        chk("t7_we",   {31'd0, reg_write}, 32'd0);
        chk("t7_addr", {27'd0, reg_wr_addr_wb}, 32'd0);
        chk("t7_data", reg_wr_data, 32'd0);
        chk("t7_busy", busy_flags, 32'd0);
        chk("t7_uf",   {31'd0, wb_underflow}, 32'd0);
        chk("t7_stall", {31'd0, stall_flag_out}, 32'd0);
        #10;
        reset = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/writeback_scoreboard.md
Name: writeback_scoreboard

Overview:
- Writeback-stage block and the producer side of the decode-stage register scoreboard.
- Registers the MEM/WB result and selects ALU or memory data.
- Drives the register-file write port (reg_write, reg_wr_addr_wb, reg_wr_data) into instruction decode.
- Keeps a per-register pending-write counter, set by decode-side issue and cleared by writeback. From it, generates the RAW stall for the two source registers being decoded.

Parameters:
- PEND_W, 2, width of each per-register pending-write counter; maximum in-flight writes per register = 2^PEND_W - 1.
- NREG, 32, number of architectural registers; fixed at 32 in this design.

Ports:
- clk  input  1  clock, rising-edge.
- reset  input  1  asynchronous, active-high.
- issue_valid  input  1  decode issued an instruction this cycle.
- issue_reg_write  input  1  issued instruction writes a register.
- issue_dst  input  5  destination register of the issued instruction.
- flush  input  1  synchronous clear of all pending counters.
- wb_valid  input  1  MEM/WB result present.
- wb_reg_write  input  1  result writes the register file.
- wb_mem_to_reg  input  1  1 selects mem_data_out, 0 selects alu_data_out.
- wb_dst  input  5  result destination register.
- alu_data_out  input  32  ALU result.
- mem_data_out  input  32  load data.
- inst_read_reg_addr1  input  5  decode source 1.
- inst_read_reg_addr2  input  5  decode source 2.
- reg_write  output  1  register-file write enable.
- reg_wr_addr_wb  output  5  register-file write address.
- reg_wr_data  output  32  register-file write data.
- stall_flag_out  output  1  RAW hazard on either decode source.
- issue_full  output  1  counter of issue_dst is saturated; decode must hold.
- busy_flags  output  32  bit i = counter[i] != 0.
- wb_underflow  output  1  sticky error flag.

Behaviour:
- Reset (async, high):
  - All counters = 0.
  - reg_write = 0, reg_wr_addr_wb = 0, reg_wr_data = 0, wb_underflow = 0.
  - Hence busy_flags = 0 and stall_flag_out = 0.
- Write port, 1-cycle latency:
  - At each rising edge, reg_write <= wb_valid & wb_reg_write & (wb_dst != 0).
  - reg_wr_addr_wb <= wb_dst.
  - reg_wr_data <= wb_mem_to_reg ? mem_data_out : alu_data_out.
  - Address and data register every cycle. Only reg_write is qualified.
- Issue (set):
  - Counter[issue_dst] is incremented when all of these hold: issue_valid, issue_reg_write, issue_dst != 0, and !issue_full.
  - Issue while issue_full = 1 is ignored and the counter does not change.
- Retire (clear):
  - At the edge where registered reg_write = 1, counter[reg_wr_addr_wb] is decremented.
  - The register file captures data on this same edge, so busy clears the cycle after data lands. No same-cycle bypass is needed in decode.
- Simultaneous issue and retire, same register: counter unchanged. Different registers: both updates apply.
- Underflow: a retire with counter = 0 leaves the counter at 0 and sets wb_underflow. The flag clears only on reset.
- Register 0:
  - Never counted and never written.
  - busy_flags[0] = 0 always.
  - A source of 0 never stalls.
- Combinational outputs, from registered counters only:
  - stall_flag_out = busy[inst_read_reg_addr1] | busy[inst_read_reg_addr2].
  - issue_full = (counter[issue_dst] == 2^PEND_W - 1).
- flush:
  - All counters go to 0 at the edge. This overrides issue and retire in the same cycle.
  - The write port is unaffected: an in-flight reg_write still completes, with no decrement and no underflow.
- Reset mid-operation: immediate clear; a pending write is lost.

Test Plan:
- Reset, then issue $5. Next cycle stall_flag_out = 1 with inst_read_reg_addr1 = 5 and busy_flags = 0x20. Then wb_valid = 1, wb_dst = 5, alu_data_out = 0x1234, wb_mem_to_reg = 0. Next cycle: reg_write = 1, reg_wr_addr_wb = 5, reg_wr_data = 0x1234. One cycle later: busy_flags = 0, stall_flag_out = 0.
- Load writeback: wb_mem_to_reg = 1, mem_data_out = 0xDEADBEEF, wb_dst = 9 -> reg_wr_data = 0xDEADBEEF, reg_wr_addr_wb = 9.
- Issue $7 three times (PEND_W = 2) -> issue_full = 1. A fourth issue is ignored. After three retires of $7, busy_flags[7] = 0 and wb_underflow = 0.
- Same-cycle issue and retire on $3 with counter = 1 -> counter stays 1 and busy_flags[3] = 1. A retire on $3 with counter 0 -> wb_underflow = 1, which stays set.
- Writes and issues to $0 -> reg_write = 0, busy_flags = 0, stall_flag_out = 0 with sources 0/0.
- Issue $4 and $6, then assert flush together with an issue of $8 -> busy_flags = 0. Assert reset mid-writeback -> all outputs 0 asynchronously, before the next clk edge.
